// File: rtl/seq_divider_if.sv
// Request/result bundle between the execution stage and the sequential divider.
interface seq_divider_if #(
  parameter int unsigned n = 32
);
  logic         start;
  logic [n-1:0] A;
  logic [n-1:0] B;
  logic [n-1:0] cociente;
  logic [n-1:0] residuo;
  logic         busy;
  logic         done;
  logic         div_cero;

  modport master (
    output start, A, B,
    input  cociente, residuo, busy, done, div_cero
  );

  modport slave (
    input  start, A, B,
    output cociente, residuo, busy, done, div_cero
  );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring shift-subtract divider, one quotient bit per clock.
// busy stalls the pipeline during iteration; done pulses with the registered result.
module seq_divider #(
  parameter int unsigned n = 32
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);

  localparam int unsigned CW = $clog2(n + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t       state;
  logic [CW-1:0] cnt;
  logic [n:0]   rem;
  logic [n-1:0] dvd;
  logic [n-1:0] dvs;

  logic [n-1:0] cociente_q;
  logic [n-1:0] residuo_q;
  logic         busy_q;
  logic         done_q;
  logic         div_cero_q;

  logic [n:0]   shifted_c;
  logic [n:0]   trial_c;
  logic [n:0]   rem_next_c;
  logic         q_bit_c;
  logic [n-1:0] dvd_next_c;

  // One iteration: the quotient bit is 1 when the trial subtraction does not borrow
  always_comb begin
    shifted_c  = {rem[n-1:0], dvd[n-1]};
    trial_c    = shifted_c - {1'b0, dvs};
    q_bit_c    = ~trial_c[n];
    rem_next_c = q_bit_c ? trial_c : shifted_c;
    dvd_next_c = {dvd[n-2:0], q_bit_c};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rem        <= '0;
      dvd        <= '0;
      dvs        <= '0;
      cociente_q <= '0;
      residuo_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_cero_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            dvd        <= bus.A;
            dvs        <= bus.B;
            rem        <= '0;
            div_cero_q <= 1'b0;
            if (bus.B == '0) begin
              // Division by zero completes immediately with a saturated quotient
              state      <= DONE;
              cociente_q <= '1;
              residuo_q  <= bus.A;
              div_cero_q <= 1'b1;
              done_q     <= 1'b1;
            end else begin
              state  <= CALC;
              cnt    <= CW'(n);
              busy_q <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end

        CALC: begin
          rem <= rem_next_c;
          dvd <= dvd_next_c;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state      <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            cociente_q <= dvd_next_c;
            residuo_q  <= rem_next_c[n-1:0];
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cociente = cociente_q;
  assign bus.residuo  = residuo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_cero = div_cero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: cycle-level arithmetic model plus directed and random divisions.
module tb_seq_divider;

  localparam int unsigned N = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  seq_divider_if #(.n(N)) bus ();

  seq_divider #(.n(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: remaining latency plus arithmetic results computed with / and %
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic         m_dz = 1'b0;
  logic [N-1:0] m_q = '0;
  logic [N-1:0] m_r = '0;
  logic [N-1:0] p_q = '0;
  logic [N-1:0] p_r = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_dz   = 1'b0;
      m_q    = '0;
      m_r    = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_q    = p_q;
        m_r    = p_r;
      end
    end else begin
      m_done = 1'b0;
      if (bus.start) begin
        if (bus.B == '0) begin
          m_done = 1'b1;
          m_dz   = 1'b1;
          m_q    = '1;
          m_r    = bus.A;
        end else begin
          m_dz   = 1'b0;
          m_left = N;
          p_q    = bus.A / bus.B;
          p_r    = bus.A % bus.B;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    check("busy",     N'(bus.busy),     N'(m_left > 0));
    check("done",     N'(bus.done),     N'(m_done));
    check("div_cero", N'(bus.div_cero), N'(m_dz));
    check("cociente", bus.cociente,     m_q);
    check("residuo",  bus.residuo,      m_r);
  end

  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // lat counts edges after the accepting edge until done is seen
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    while (!bus.done && lat < int'(N) + 10) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    check("done_timeout", N'(bus.done), N'(1));
  endtask

  task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b,
                        output int lat, output int busy_n);
    start_op(a, b);
    wait_done(lat, busy_n);
  endtask

  initial begin
    int           lat;
    int           busy_n;
    int           prev_cyc;
    logic [N-1:0] a, b;
    logic [N-1:0] qa[4];
    logic [N-1:0] qb[4];

    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cociente", bus.cociente, '0);
    check("rst_busy",     N'(bus.busy), '0);
    @(negedge clk);
    rst = 1'b0;

    // 100 / 7
    do_div(N'(100), N'(7), lat, busy_n);
    check("t1_busy_cycles", N'(busy_n), N'(32));
    check("t1_latency",     N'(lat),    N'(32));
    check("t1_q",           bus.cociente, N'(14));
    check("t1_r",           bus.residuo,  N'(2));
    check("t1_dz",          N'(bus.div_cero), N'(0));
    @(negedge clk);
    check("t1_done_drop",   N'(bus.done), N'(0));

    do_div(32'hFFFF_FFFF, N'(1), lat, busy_n);
    check("t2_q", bus.cociente, 32'hFFFF_FFFF);
    check("t2_r", bus.residuo,  N'(0));
    do_div(N'(5), N'(9), lat, busy_n);
    check("t2b_q", bus.cociente, N'(0));
    check("t2b_r", bus.residuo,  N'(5));

    // Division by zero
    do_div(N'(1234), N'(0), lat, busy_n);
    check("t3_latency", N'(lat),    N'(0));
    check("t3_busy",    N'(busy_n), N'(0));
    check("t3_q",       bus.cociente, 32'hFFFF_FFFF);
    check("t3_r",       bus.residuo,  N'(1234));
    check("t3_dz",      N'(bus.div_cero), N'(1));
    do_div(N'(20), N'(6), lat, busy_n);
    check("t3b_dz", N'(bus.div_cero), N'(0));
    check("t3b_q",  bus.cociente, N'(3));

    // start during CALC must be ignored
    start_op(N'(100), N'(7));
    repeat (9) @(negedge clk);
    bus.A     = N'(50);
    bus.B     = N'(5);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, busy_n);
    check("t4_q", bus.cociente, N'(14));
    check("t4_r", bus.residuo,  N'(2));

    // Back-to-back with start held high
    for (int k = 0; k < 4; k++) begin
      qa[k] = N'($urandom);
      qb[k] = N'($urandom_range(1, 1000));
    end
    @(negedge clk);
    bus.A     = qa[0];
    bus.B     = qb[0];
    bus.start = 1'b1;
    prev_cyc  = 0;
    for (int k = 0; k < 4; k++) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!bus.done && lat < 100);
      check("t5_done_timeout", N'(bus.done), N'(1));
      check("t5_q", bus.cociente, qa[k] / qb[k]);
      check("t5_r", bus.residuo,  qa[k] % qb[k]);
      if (k > 0) check("t5_spacing", N'(cyc - prev_cyc), N'(33));
      prev_cyc = cyc;
      if (k < 3) begin
        bus.A = qa[k+1];
        bus.B = qb[k+1];
      end else begin
        bus.start = 1'b0;
      end
    end

    // Async reset in the middle of CALC
    start_op(N'(100), N'(7));
    repeat (14) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6_busy",     N'(bus.busy),     N'(0));
    check("t6_done",     N'(bus.done),     N'(0));
    check("t6_cociente", bus.cociente,     N'(0));
    check("t6_residuo",  bus.residuo,      N'(0));
    check("t6_dz",       N'(bus.div_cero), N'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      check("t6_no_done", N'(bus.done), N'(0));
    end
    do_div(N'(9), N'(3), lat, busy_n);
    check("t6_q", bus.cociente, N'(3));
    check("t6_r", bus.residuo,  N'(0));

    // Random operands, including zero and small divisors
    for (int i = 0; i < 40; i++) begin
      a = N'($urandom);
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = N'($urandom_range(1, 16));
        2:       b = N'($urandom) >> $urandom_range(0, 31);
        default: b = N'($urandom);
      endcase
      do_div(a, b, lat, busy_n);
      if (b == '0) begin
        check("rnd_q0", bus.cociente, '1);
        check("rnd_r0", bus.residuo,  a);
      end else begin
        check("rnd_q",  bus.cociente, a / b);
        check("rnd_r",  bus.residuo,  a % b);
        check("rnd_lat", N'(lat), N'(N));
      end
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
